// File: rtl/dreg_latency_checker.sv
// dreg_latency_checker: flags cycles where d_r differs from d sampled LAT cycles earlier (free-running, load-gated or load-gated with hold check)
module dreg_latency_checker #(
  parameter int WIDTH = 16,
  parameter int LAT   = 1,
  parameter int MODE  = 1,
  parameter int CNT_W = 8
)(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  input  logic [WIDTH-1:0] d_r,
  input  logic             clr_err,
  output logic             warm,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0] fail_exp,
  output logic [WIDTH-1:0] fail_act
);
  localparam int FW = $clog2(LAT + 1);
  if (LAT < 1 || LAT > 8 || MODE < 1 || MODE > 3) begin : g_bad_param
    $error("dreg_latency_checker: illegal LAT or MODE");
  end
  logic [WIDTH-1:0] d_hist [LAT];
  logic [LAT-1:0]   ld_hist;
  logic [FW-1:0]    fill;
  logic [WIDTH-1:0] d_r_prev;
  logic             hold;
  logic             fail;
  logic [WIDTH-1:0] exp_v;
  assign warm = fill == FW'(LAT);
  // In hold mode the "expected" value is the previous d_r, which is also what gets captured
  always_comb begin
    hold  = MODE == 3 && !ld_hist[LAT-1];
    exp_v = hold ? d_r_prev : d_hist[LAT-1];
    fail  = en && warm && d_r != exp_v && (MODE != 2 || ld_hist[LAT-1]);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LAT; i++) d_hist[i] <= '0;
      ld_hist    <= '0;
      fill       <= '0;
      d_r_prev   <= '0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
      fail_exp   <= '0;
      fail_act   <= '0;
    end else begin
      d_hist[0]  <= d;
      ld_hist[0] <= load;
      for (int i = 1; i < LAT; i++) begin
        d_hist[i]  <= d_hist[i-1];
        ld_hist[i] <= ld_hist[i-1];
      end
      fill       <= warm ? fill : fill + FW'(1);
      d_r_prev   <= d_r;
      err        <= fail;
      err_sticky <= fail || (err_sticky && !clr_err);
      err_cnt    <= clr_err ? CNT_W'(fail) : err_cnt + CNT_W'(fail && err_cnt != '1);
      if (fail && (!err_sticky || clr_err)) begin
        fail_exp <= exp_v;
        fail_act <= d_r;
      end else if (clr_err) begin
        fail_exp <= '0;
        fail_act <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dreg_latency_checker.sv
// tb_dreg_latency_checker: five checker configurations driven by shared directed and random stimulus, checked against a time-indexed model
module tb_dreg_latency_checker;
  localparam int NI = 5;
  function automatic int lat_of(int k);
    return k == 1 ? 2 : k == 3 ? 4 : k == 4 ? 3 : 1;
  endfunction
  function automatic int mode_of(int k);
    return k == 1 ? 2 : (k == 2 || k == 4) ? 3 : 1;
  endfunction
  function automatic int cw_of(int k);
    return (k == 2 || k == 3) ? 2 : k == 4 ? 4 : 8;
  endfunction
  logic        clk = 0;
  logic        reset_n = 0;
  logic        en = 0;
  logic        load = 0;
  logic        clr_err = 0;
  logic [15:0] d = 0;
  logic [15:0] dr [NI];
  logic        warm_o [NI];
  logic        err_o [NI];
  logic        st_o [NI];
  logic [7:0]  cnt_o [NI];
  logic [15:0] fe_o [NI];
  logic [15:0] fa_o [NI];
  int checks = 0;
  int errors = 0;
  bit run = 0;
  always #5 clk = ~clk;
  for (genvar k = 0; k < NI; k++) begin : g_dut
    logic [cw_of(k)-1:0] c;
    dreg_latency_checker #(.WIDTH(16), .LAT(lat_of(k)), .MODE(mode_of(k)), .CNT_W(cw_of(k))) u_dut (
      .clk(clk), .reset_n(reset_n), .en(en), .d(d), .load(load), .d_r(dr[k]), .clr_err(clr_err),
      .warm(warm_o[k]), .err(err_o[k]), .err_sticky(st_o[k]), .err_cnt(c),
      .fail_exp(fe_o[k]), .fail_act(fa_o[k]));
    assign cnt_o[k] = 8'(c);
  end
  // Model: every sampled d/load is logged by edge index; the expected value is simply the entry LAT edges back
  logic [15:0] dq [$];
  logic        lq [$];
  int          n = 0;
  int          since [NI];
  logic [15:0] prev [NI];
  logic        m_err [NI];
  logic        m_st [NI];
  int          m_cnt [NI];
  logic [15:0] m_fe [NI];
  logic [15:0] m_fa [NI];
  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask
  initial begin
    for (int k = 0; k < NI; k++) begin
      since[k] = 0; prev[k] = 0; m_err[k] = 0; m_st[k] = 0; m_cnt[k] = 0; m_fe[k] = 0; m_fa[k] = 0;
    end
    forever begin : model
      int lat, mode;
      logic [15:0] e;
      logic l, f;
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        for (int k = 0; k < NI; k++) begin
          since[k] = 0; prev[k] = 0; m_err[k] = 0; m_st[k] = 0; m_cnt[k] = 0; m_fe[k] = 0; m_fa[k] = 0;
        end
      end else begin
        for (int k = 0; k < NI; k++) begin
          lat = lat_of(k);
          mode = mode_of(k);
          f = 0;
          e = 0;
          if (en && since[k] >= lat) begin
            e = dq[n-lat];
            l = lq[n-lat];
            if (mode == 3 && !l) e = prev[k];
            f = dr[k] != e && (mode != 2 || l);
          end
          if (f && (!m_st[k] || clr_err)) begin
            m_fe[k] = e; m_fa[k] = dr[k];
          end else if (clr_err) begin
            m_fe[k] = 0; m_fa[k] = 0;
          end
          if (clr_err) m_cnt[k] = f ? 1 : 0;
          else if (f && m_cnt[k] < (1 << cw_of(k)) - 1) m_cnt[k]++;
          m_st[k] = f || (m_st[k] && !clr_err);
          m_err[k] = f;
          prev[k] = dr[k];
          if (since[k] < lat) since[k]++;
        end
        dq.push_back(d);
        lq.push_back(load);
        n++;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (run)
      for (int k = 0; k < NI; k++) begin
        chk("warm", k, 32'(warm_o[k]), 32'(since[k] >= lat_of(k)));
        chk("err", k, 32'(err_o[k]), 32'(m_err[k]));
        chk("err_sticky", k, 32'(st_o[k]), 32'(m_st[k]));
        chk("err_cnt", k, 32'(cnt_o[k]), 32'(m_cnt[k]));
        chk("fail_exp", k, 32'(fe_o[k]), 32'(m_fe[k]));
        chk("fail_act", k, 32'(fa_o[k]), 32'(m_fa[k]));
      end
  end
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic set_dr(input logic [15:0] v);
    for (int k = 0; k < NI; k++) dr[k] = v;
  endtask
  initial begin
    set_dr(16'h0);
    tick;
    tick;
    run = 1;
    reset_n = 1; en = 1; load = 1; d = 16'h1234;
    tick;
    set_dr(16'h1234);
    tick;
    chk("t1_no_err", 0, 32'(err_o[0]), 0);
    set_dr(16'h1235);
    tick;
    chk("t1_err", 0, 32'(err_o[0]), 1);
    chk("t1_cnt", 0, 32'(cnt_o[0]), 1);
    chk("t1_fexp", 0, 32'(fe_o[0]), 32'h1234);
    chk("t1_fact", 0, 32'(fa_o[0]), 32'h1235);
    chk("t1_sticky", 0, 32'(st_o[0]), 1);
    load = 0; set_dr(16'h0010);
    tick;
    clr_err = 1;
    tick;
    chk("t3_clr_sticky", 2, 32'(st_o[2]), 0);
    chk("t3_clr_cnt", 2, 32'(cnt_o[2]), 0);
    clr_err = 0; set_dr(16'h0011);
    tick;
    chk("t3_err", 2, 32'(err_o[2]), 1);
    chk("t3_fexp", 2, 32'(fe_o[2]), 32'h0010);
    chk("t3_fact", 2, 32'(fa_o[2]), 32'h0011);
    chk("t2_gated", 1, 32'(err_o[1]), 0);
    for (int i = 0; i < 5; i++) begin
      set_dr(16'h0020 + 16'(i));
      tick;
    end
    chk("t5_sat", 2, 32'(cnt_o[2]), 3);
    set_dr(16'h0030); clr_err = 1;
    tick;
    chk("t5_clrfail_cnt", 2, 32'(cnt_o[2]), 1);
    chk("t5_clrfail_sticky", 2, 32'(st_o[2]), 1);
    chk("t5_clrfail_fexp", 2, 32'(fe_o[2]), 32'h0024);
    chk("t5_clrfail_fact", 2, 32'(fa_o[2]), 32'h0030);
    tick;
    chk("t5_clr_cnt", 2, 32'(cnt_o[2]), 0);
    chk("t5_clr_sticky", 2, 32'(st_o[2]), 0);
    chk("t5_clr_fexp", 2, 32'(fe_o[2]), 0);
    chk("t5_clr_fact", 2, 32'(fa_o[2]), 0);
    clr_err = 0; load = 1; d = 16'hABCD;
    tick;
    load = 0; d = 16'h0;
    tick;
    chk("t2_no_err", 1, 32'(err_o[1]), 0);
    set_dr(16'h0000);
    tick;
    chk("t2_err", 1, 32'(err_o[1]), 1);
    chk("t6_pre_sticky", 0, 32'(st_o[0]), 1);
    reset_n = 0;
    #1;
    chk("t6_sticky", 0, 32'(st_o[0]), 0);
    chk("t6_cnt", 0, 32'(cnt_o[0]), 0);
    chk("t6_warm", 0, 32'(warm_o[0]), 0);
    chk("t6_fexp", 0, 32'(fe_o[0]), 0);
    tick;
    tick;
    reset_n = 1; load = 1; d = 16'h0001; set_dr(16'hFFFF);
    tick;
    tick;
    tick;
    chk("t4_warm3", 3, 32'(warm_o[3]), 0);
    chk("t4_err3", 3, 32'(err_o[3]), 0);
    tick;
    chk("t4_warm4", 3, 32'(warm_o[3]), 1);
    chk("t4_err4", 3, 32'(err_o[3]), 0);
    tick;
    chk("t4_err5", 3, 32'(err_o[3]), 1);
    for (int c = 0; c < 3000; c++) begin
      en = $urandom_range(9) != 0;
      load = 1'($urandom_range(1));
      clr_err = $urandom_range(19) == 0;
      d = 16'($urandom);
      for (int k = 0; k < NI; k++) begin
        int r;
        r = $urandom_range(99);
        if (r < 70 && n >= lat_of(k)) dr[k] = dq[n-lat_of(k)];
        else if (r >= 85) dr[k] = 16'($urandom);
      end
      if ($urandom_range(299) == 0) begin
        reset_n = 0;
        tick;
        tick;
        reset_n = 1;
      end
      tick;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
